// File: rtl/fixed_mac_seq.sv
// fixed_mac_seq: sequential sign-magnitude fixed-point multiply-accumulate.
// Each accepted (a,b) pair is multiplied by an iterative shift-add unit, the
// product is rescaled and saturated, then added into a saturating
// sign-magnitude accumulator. One result is presented per vector (in_last).
module fixed_mac_seq #(
    parameter int WIDTH     = 12,
    parameter int FRAC_BITS = 6,
    parameter int INT_BITS  = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_acc,
    output logic             out_overflow
);

    localparam int MAG_W  = INT_BITS + FRAC_BITS;
    localparam int PROD_W = 2 * MAG_W;
    localparam int SH_W   = PROD_W - FRAC_BITS;
    localparam int CNT_W  = $clog2(MAG_W + 1);
    localparam logic [MAG_W-1:0] MAX_MAG = '1;

    typedef enum logic [1:0] {IDLE, MUL, ACC, DONE} state_t;

    state_t state, next_state;

    logic [PROD_W-1:0] mcand;
    logic [PROD_W-1:0] prod;
    logic [MAG_W-1:0]  mplier;
    logic [CNT_W-1:0]  cnt;
    logic              op_sign;
    logic              op_last;
    logic [MAG_W-1:0]  acc_mag;
    logic              acc_sign;
    logic              ovf;

    logic              transfer;
    logic [SH_W-1:0]   prod_shift;
    logic              prod_sat;
    logic [MAG_W-1:0]  prod_mag;
    logic              prod_sign;
    logic [MAG_W:0]    mag_sum;
    logic [MAG_W-1:0]  new_mag;
    logic              new_sign;
    logic              add_sat;

    assign transfer     = in_valid && in_ready;
    assign out_acc      = {acc_sign, acc_mag};
    assign out_overflow = ovf;

    // State register; reset returns to IDLE and abandons any partial vector.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // Next-state logic: MUL lasts one cycle per magnitude bit, ACC one cycle.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (transfer) next_state = MUL;
            MUL:  if (cnt == CNT_W'(MAG_W - 1)) next_state = ACC;
            ACC:  next_state = op_last ? DONE : IDLE;
            DONE: if (out_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Handshake outputs; in_ready is held low while reset is asserted.
    always_comb begin
        in_ready  = rst_n && (state == IDLE);
        out_valid = (state == DONE);
    end

    // Rescale the product, saturate it, then form the sign-magnitude sum.
    always_comb begin
        prod_shift = prod[PROD_W-1:FRAC_BITS];
        prod_sat   = (prod_shift > SH_W'(MAX_MAG));
        prod_mag   = prod_sat ? MAX_MAG : prod_shift[MAG_W-1:0];
        prod_sign  = op_sign && (prod_mag != '0);
        mag_sum    = '0;
        add_sat    = 1'b0;
        new_mag    = acc_mag;
        new_sign   = acc_sign;
        if (acc_sign == prod_sign) begin
            mag_sum  = {1'b0, acc_mag} + {1'b0, prod_mag};
            add_sat  = mag_sum[MAG_W];
            new_mag  = add_sat ? MAX_MAG : mag_sum[MAG_W-1:0];
            new_sign = acc_sign && (new_mag != '0);
        end else if (acc_mag >= prod_mag) begin
            new_mag  = acc_mag - prod_mag;
            new_sign = acc_sign && (new_mag != '0);
        end else begin
            new_mag  = prod_mag - acc_mag;
            new_sign = prod_sign;
        end
    end

    // Datapath: operand capture, shift-add steps, accumulate and release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand    <= '0;
            prod     <= '0;
            mplier   <= '0;
            cnt      <= '0;
            op_sign  <= 1'b0;
            op_last  <= 1'b0;
            acc_mag  <= '0;
            acc_sign <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (clear) begin
                        acc_mag  <= '0;
                        acc_sign <= 1'b0;
                        ovf      <= 1'b0;
                    end
                    if (transfer) begin
                        mcand   <= {{(PROD_W - MAG_W){1'b0}}, in_a[MAG_W-1:0]};
                        mplier  <= in_b[MAG_W-1:0];
                        prod    <= '0;
                        cnt     <= '0;
                        op_sign <= in_a[WIDTH-1] ^ in_b[WIDTH-1];
                        op_last <= in_last;
                    end
                end
                MUL: begin
                    if (mplier[0]) prod <= prod + mcand;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                end
                ACC: begin
                    acc_mag  <= new_mag;
                    acc_sign <= new_sign;
                    ovf      <= ovf | prod_sat | add_sat;
                end
                DONE: begin
                    if (out_ready) begin
                        acc_mag  <= '0;
                        acc_sign <= 1'b0;
                        ovf      <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
